// File: rtl/ocra1_rx_deser.sv
// OCRA1 four-channel serial receiver: synchronises the SPI-style inputs, deserialises 24-bit words.
// Optional macro OCRA1_RX_LDAC_EN holds accepted words until the next ldacn falling edge.
module ocra1_rx_deser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        oc1_clk_i,
  input  logic        oc1_syncn_i,
  input  logic        oc1_ldacn_i,
  input  logic        oc1_sdox_i,
  input  logic        oc1_sdoy_i,
  input  logic        oc1_sdoz_i,
  input  logic        oc1_sdoz2_i,
  output logic [23:0] datax_o,
  output logic [23:0] datay_o,
  output logic [23:0] dataz_o,
  output logic [23:0] dataz2_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [15:0] frame_cnt_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  // Synchroniser bit order: {ldacn, syncn, sclk, sdoz2, sdoz, sdoy, sdox}
  localparam logic [6:0] SYNC_RST = 7'b1100000;

  state_t      state_q, state_d;
  logic [6:0]  sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [1:0]  settle_q, settle_d;
  logic        arm_q, arm_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shx_q, shx_d, shy_q, shy_d, shz_q, shz_d, shz2_q, shz2_d;
  logic [23:0] datax_q, datax_d, datay_q, datay_d, dataz_q, dataz_d, dataz2_q, dataz2_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        sclk_fall, sync_fall, sync_rise, accept;
`ifdef OCRA1_RX_LDAC_EN
  logic [23:0] pendx_q, pendx_d, pendy_q, pendy_d, pendz_q, pendz_d, pendz2_q, pendz2_d;
  logic        pend_q, pend_d;
  logic        ldac_low, ldac_fall;
`endif

  assign sclk_fall = ~sync2_q[4] & sync3_q[4];
  // arm_q blocks a syncn low that was already in progress when reset released
  assign sync_fall = ~sync2_q[5] & sync3_q[5] & arm_q;
  assign sync_rise = sync2_q[5] & ~sync3_q[5];
`ifdef OCRA1_RX_LDAC_EN
  assign ldac_low  = ~sync2_q[6];
  assign ldac_fall = ~sync2_q[6] & sync3_q[6];
`endif

  always_comb begin
    state_d     = state_q;
    sync1_d     = {oc1_ldacn_i, oc1_syncn_i, oc1_clk_i, oc1_sdoz2_i, oc1_sdoz_i, oc1_sdoy_i, oc1_sdox_i};
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    settle_d    = {settle_q[0], 1'b1};
    arm_d       = arm_q | (settle_q[1] & sync2_q[5]);
    bit_cnt_d   = bit_cnt_q;
    shx_d       = shx_q;
    shy_d       = shy_q;
    shz_d       = shz_q;
    shz2_d      = shz2_q;
    datax_d     = datax_q;
    datay_d     = datay_q;
    dataz_d     = dataz_q;
    dataz2_d    = dataz2_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    accept      = 1'b0;
`ifdef OCRA1_RX_LDAC_EN
    pendx_d     = pendx_q;
    pendy_d     = pendy_q;
    pendz_d     = pendz_q;
    pendz2_d    = pendz2_q;
    pend_d      = pend_q;
`endif

    case (state_q)
      IDLE: begin
        if (sync_fall) begin
          bit_cnt_d = 5'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // A clock fall in the same cycle as the syncn rise still counts toward the length
        if (sclk_fall) begin
          shx_d  = {shx_q[22:0], sync2_q[0]};
          shy_d  = {shy_q[22:0], sync2_q[1]};
          shz_d  = {shz_q[22:0], sync2_q[2]};
          shz2_d = {shz2_q[22:0], sync2_q[3]};
          if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        if (sync_rise) state_d = CHECK;
      end
      CHECK: begin
        if (bit_cnt_q == 5'd24) accept = 1'b1;
        else                    err_d  = 1'b1;
        if (sync_fall) begin
          bit_cnt_d = 5'd0;
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef OCRA1_RX_LDAC_EN
    if (accept) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (ldac_low) begin
        datax_d  = shx_q;
        datay_d  = shy_q;
        dataz_d  = shz_q;
        dataz2_d = shz2_q;
        valid_d  = 1'b1;
        pend_d   = 1'b0;
      end else begin
        pendx_d  = shx_q;
        pendy_d  = shy_q;
        pendz_d  = shz_q;
        pendz2_d = shz2_q;
        pend_d   = 1'b1;
      end
    end else if (pend_q && ldac_fall) begin
      datax_d  = pendx_q;
      datay_d  = pendy_q;
      dataz_d  = pendz_q;
      dataz2_d = pendz2_q;
      valid_d  = 1'b1;
      pend_d   = 1'b0;
    end
`else
    if (accept) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      datax_d     = shx_q;
      datay_d     = shy_q;
      dataz_d     = shz_q;
      dataz2_d    = shz2_q;
      valid_d     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      sync3_q     <= SYNC_RST;
      settle_q    <= 2'b00;
      arm_q       <= 1'b0;
      bit_cnt_q   <= 5'd0;
      shx_q       <= 24'd0;
      shy_q       <= 24'd0;
      shz_q       <= 24'd0;
      shz2_q      <= 24'd0;
      datax_q     <= 24'd0;
      datay_q     <= 24'd0;
      dataz_q     <= 24'd0;
      dataz2_q    <= 24'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      settle_q    <= settle_d;
      arm_q       <= arm_d;
      bit_cnt_q   <= bit_cnt_d;
      shx_q       <= shx_d;
      shy_q       <= shy_d;
      shz_q       <= shz_d;
      shz2_q      <= shz2_d;
      datax_q     <= datax_d;
      datay_q     <= datay_d;
      dataz_q     <= dataz_d;
      dataz2_q    <= dataz2_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef OCRA1_RX_LDAC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendx_q  <= 24'd0;
      pendy_q  <= 24'd0;
      pendz_q  <= 24'd0;
      pendz2_q <= 24'd0;
      pend_q   <= 1'b0;
    end else begin
      pendx_q  <= pendx_d;
      pendy_q  <= pendy_d;
      pendz_q  <= pendz_d;
      pendz2_q <= pendz2_d;
      pend_q   <= pend_d;
    end
  end
`endif

  assign datax_o     = datax_q;
  assign datay_o     = datay_q;
  assign dataz_o     = dataz_q;
  assign dataz2_o    = dataz2_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = (state_q == SHIFT);

endmodule

// File: tb/tb_ocra1_rx_deser.sv
// Self-checking bench for ocra1_rx_deser: randomized frames against a word-level reference model.
// Exercises the OCRA1_RX_LDAC_EN path when that macro is defined.
module tb_ocra1_rx_deser;

  logic        clk = 1'b0;
  logic        rst_n, sclk, syncn, ldacn, sdox, sdoy, sdoz, sdoz2;
  logic [23:0] datax, datay, dataz, dataz2;
  logic        valid, err, busy;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          errors = 0;
  int          valid_seen = 0;
  int          err_seen = 0;
  int          exp_valid = 0;
  int          exp_err = 0;
  logic [95:0] m_out;
  logic [15:0] m_cnt;
  logic [95:0] got;

  ocra1_rx_deser dut (
    .clk(clk), .rst_n(rst_n), .oc1_clk_i(sclk), .oc1_syncn_i(syncn), .oc1_ldacn_i(ldacn),
    .oc1_sdox_i(sdox), .oc1_sdoy_i(sdoy), .oc1_sdoz_i(sdoz), .oc1_sdoz2_i(sdoz2),
    .datax_o(datax), .datay_o(datay), .dataz_o(dataz), .dataz2_o(dataz2),
    .valid_o(valid), .err_o(err), .frame_cnt_o(frame_cnt), .busy_o(busy)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (valid) valid_seen++;
    if (err)   err_seen++;
  end

  assign got = {datax, datay, dataz, dataz2};

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference model: a frame is accepted only when exactly 24 clock falls were sent
  task automatic model_frame(input logic [23:0] wx, wy, wz, wz2, input int nbits);
    if (nbits == 24) begin
      m_out = {wx, wy, wz, wz2};
      m_cnt = m_cnt + 16'd1;
      exp_valid++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic send_frame(input logic [23:0] wx, wy, wz, wz2, input int nbits, hi, lo,
                            input bit coinc, input bit raise);
    logic [63:0] vx, vy, vz, vz2;
    vx = {40'd0, wx}; vy = {40'd0, wy}; vz = {40'd0, wz}; vz2 = {40'd0, wz2};
    syncn = 1'b0;
    step(2);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk = 1'b1;
      sdox = vx[i]; sdoy = vy[i]; sdoz = vz[i]; sdoz2 = vz2[i];
      step(hi);
      sclk = 1'b0;
      if (i == 0 && coinc) syncn = 1'b1;
      step(lo);
    end
    if (raise) syncn = 1'b1;
  endtask

  task automatic compare_state(input string tag);
    checks++;
    if (got !== m_out) begin
      errors++;
      $display("[TB] FAIL %s data: got %h expected %h", tag, got, m_out);
    end
    checks++;
    if (frame_cnt !== m_cnt) begin
      errors++;
      $display("[TB] FAIL %s frame_cnt: got %h expected %h", tag, frame_cnt, m_cnt);
    end
    checks++;
    if (valid_seen !== exp_valid) begin
      errors++;
      $display("[TB] FAIL %s valid pulses: got %0d expected %0d", tag, valid_seen, exp_valid);
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("[TB] FAIL %s err pulses: got %0d expected %0d", tag, err_seen, exp_err);
    end
  endtask

  task automatic test_reset();
    m_out = '0;
    m_cnt = '0;
    checks++;
    if ({got, frame_cnt, valid, err, busy} !== 115'd0) begin
      errors++;
      $display("[TB] FAIL reset outputs: got %h expected 0", {got, frame_cnt, valid, err, busy});
    end
  endtask

  task automatic test_basic();
    send_frame(24'hA5A5A5, 24'h123456, 24'h800000, 24'h7FFFFF, 24, 16, 16, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic busy: got %b expected 1", busy);
    end
    syncn = 1'b1;
    step(3);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic early valid: got %b expected 0", valid);
    end
    step(1);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic latency valid: got %b expected 1", valid);
    end
    model_frame(24'hA5A5A5, 24'h123456, 24'h800000, 24'h7FFFFF, 24);
    step(6);
    compare_state("basic");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic idle busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_errors();
    send_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444, 23, 2, 2, 1'b0, 1'b1);
    model_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444, 23);
    step(8);
    send_frame(24'h555555, 24'h666666, 24'h777777, 24'h888888, 25, 2, 2, 1'b0, 1'b1);
    model_frame(24'h555555, 24'h666666, 24'h777777, 24'h888888, 25);
    step(8);
    compare_state("short_long");
    // 56 falls would alias to 24 in a 5-bit counter that wrapped instead of saturating
    send_frame(24'h0F0F0F, 24'hF0F0F0, 24'h00FF00, 24'hFF00FF, 56, 2, 2, 1'b0, 1'b1);
    model_frame(24'h0F0F0F, 24'hF0F0F0, 24'h00FF00, 24'hFF00FF, 56);
    step(8);
    compare_state("saturate");
  endtask

  task automatic test_back_to_back();
    logic [23:0] a[4], b[4];
    for (int k = 0; k < 4; k++) begin
      a[k] = 24'($urandom);
      b[k] = 24'($urandom);
    end
    send_frame(a[0], a[1], a[2], a[3], 24, 2, 2, 1'b0, 1'b1);
    model_frame(a[0], a[1], a[2], a[3], 24);
    step(1);
    send_frame(b[0], b[1], b[2], b[3], 24, 2, 2, 1'b0, 1'b1);
    model_frame(b[0], b[1], b[2], b[3], 24);
    step(8);
    compare_state("back_to_back");
  endtask

  task automatic test_random();
    logic [23:0] w[4];
    int nb, hi, lo;
    bit co;
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 4; k++) w[k] = 24'($urandom);
      nb = ($urandom_range(0, 1) == 1) ? 24 : int'($urandom_range(20, 28));
      hi = int'($urandom_range(2, 4));
      lo = int'($urandom_range(2, 4));
      co = 1'($urandom_range(0, 1));
      send_frame(w[0], w[1], w[2], w[3], nb, hi, lo, co, 1'b1);
      model_frame(w[0], w[1], w[2], w[3], nb);
      step(8);
      compare_state($sformatf("random%0d_n%0d_c%0d", f, nb, co));
    end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] y;
    syncn = 1'b0;
    step(2);
    for (int i = 0; i < 12; i++) begin
      sclk = 1'b1; sdox = 1'b1; sdoy = 1'b0; sdoz = 1'b1; sdoz2 = 1'b0;
      step(2);
      sclk = 1'b0;
      step(2);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midframe busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({got, frame_cnt, valid, err, busy} !== 115'd0) begin
      errors++;
      $display("[TB] FAIL midframe reset outputs: got %h expected 0", {got, frame_cnt, valid, err, busy});
    end
    m_out = '0;
    m_cnt = '0;
    step(3);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sclk = 1'b1;
      step(2);
      sclk = 1'b0;
      step(2);
    end
    syncn = 1'b1;
    step(8);
    compare_state("abandoned");
    y = 24'($urandom);
    send_frame(24'h000001, y, 24'h000000, 24'hFFFFFF, 24, 3, 3, 1'b0, 1'b1);
    model_frame(24'h000001, y, 24'h000000, 24'hFFFFFF, 24);
    step(8);
    compare_state("after_reset");
  endtask

  task automatic test_wrap();
    // Preload the counter directly; 65535 real frames would dominate the run time
    force dut.frame_cnt_q = 16'hFFFF;
    step(2);
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    step(1);
    send_frame(24'h00ABCD, 24'h0000FF, 24'hFEDCBA, 24'h010203, 24, 2, 3, 1'b0, 1'b1);
    model_frame(24'h00ABCD, 24'h0000FF, 24'hFEDCBA, 24'h010203, 24);
    step(8);
    compare_state("wrap");
  endtask

`ifdef OCRA1_RX_LDAC_EN
  task automatic test_ldac();
    logic [95:0] held;
    held = m_out;
    ldacn = 1'b1;
    step(4);
    send_frame(24'h135791, 24'h246802, 24'h112233, 24'h445566, 24, 2, 2, 1'b0, 1'b1);
    model_frame(24'h135791, 24'h246802, 24'h112233, 24'h445566, 24);
    step(8);
    send_frame(24'hCAFE01, 24'hBEEF02, 24'hD00D03, 24'hF00D04, 24, 2, 2, 1'b0, 1'b1);
    model_frame(24'hCAFE01, 24'hBEEF02, 24'hD00D03, 24'hF00D04, 24);
    step(8);
    exp_valid = exp_valid - 2;
    checks++;
    if (valid_seen !== exp_valid || got !== held) begin
      errors++;
      $display("[TB] FAIL ldac held: got valid %0d data %h expected valid %0d data %h",
               valid_seen, got, exp_valid, held);
    end
    ldacn = 1'b0;
    step(4);
    exp_valid++;
    compare_state("ldac_release");
  endtask
`else
  task automatic test_ldac();
    logic [23:0] w;
    w = 24'($urandom);
    ldacn = 1'b1;
    step(4);
    send_frame(w, ~w, 24'h5A5A5A, 24'hC3C3C3, 24, 2, 2, 1'b0, 1'b1);
    model_frame(w, ~w, 24'h5A5A5A, 24'hC3C3C3, 24);
    step(8);
    compare_state("ldac_ignored");
    ldacn = 1'b0;
    step(6);
    compare_state("ldac_fall_ignored");
  endtask
`endif

  initial begin
    rst_n = 1'b0; sclk = 1'b0; syncn = 1'b1; ldacn = 1'b0;
    sdox = 1'b0; sdoy = 1'b0; sdoz = 1'b0; sdoz2 = 1'b0;
    #1;
    test_reset();
    step(3);
    rst_n = 1'b1;
    step(4);
    test_basic();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_wrap();
    test_ldac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
